uart_tx_port: RTL and testbench
===============================

Name: uart_tx_port

Overview:
- Memory-mapped UART transmitter that answers the NextCore IO bus.
- The core initiates writes on io_addr/io_data/io_we. This block accepts them, buffers one byte, and serialises 8N1 frames on the tx pin.
- It also drives the io_uart_io_reg and io_uart_csr_reg views that the core and bench observe.
- It sits beside the GPIO register block on the same 8-bit IO address space.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Must be >= 2; the design fails elaboration otherwise.
- DATA_ADDR, 8'h00: IO address of the transmit data register.
- CSR_ADDR, 8'h04: IO address of the control/status register.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- io_we  input  1  IO write strobe, one cycle per write.
- io_addr  input  8  IO write address.
- io_data  input  32  IO write data.
- tx  output  1  serial line; idles high.
- io_uart_io_reg  output  32  last byte accepted into the holding register, zero-extended.
- io_uart_csr_reg  output  32  status view (see CSR bits below).

Behaviour:
- Reset (rst low, asynchronous, effective mid-frame):
  - tx=1, holding register empty, FSM to IDLE, baud counter 0, bit index 0.
  - io_uart_io_reg=0, io_uart_csr_reg=0.
- CSR bits:
  - [0] busy: FSM != IDLE.
  - [1] hold_full.
  - [2] overrun: sticky; cleared by a CSR write with io_data[2]=1 (write-1-to-clear).
  - All other bits read 0.
- Data write (io_we=1, io_addr=DATA_ADDR):
  - If the holding register is empty, or is being drained by the FSM in the same cycle: latch io_data[7:0], set hold_full, update io_uart_io_reg.
  - Otherwise: drop the write, leave the holding register unchanged, set overrun.
- Writes to any other address are ignored and have no side effects.
- Simultaneous overrun set and W1C clear in one cycle: set wins.
- FSM states: IDLE, START, DATA, STOP. Each non-IDLE state lasts CLKS_PER_BIT cycles, timed by the baud counter.
  - IDLE: if hold_full, load the shift register, clear hold_full, clear the baud counter, go to START.
  - START: tx=0.
  - DATA: tx=shift[0], LSB first, bit index 0..7. Shift on each bit boundary. After bit 7 go to STOP.
  - STOP: tx=1. At the end of the bit, if hold_full, reload and go directly to START (no idle gap); else go to IDLE.
- tx is a registered output.
- Latency:
  - A data write sampled at edge N sets hold_full after edge N.
  - The FSM leaves IDLE at edge N+1.
  - tx falls after edge N+2.
- Frame length is exactly 10*CLKS_PER_BIT cycles; back-to-back frames have zero gap.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps; width is $clog2(CLKS_PER_BIT).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx carries XOR of the 8 data bits (even parity), or its inverse when CSR bit [3] (odd parity) = 1.
  - CSR bit [3] is read/write through CSR writes.
  - Frame length is 11*CLKS_PER_BIT cycles.
- When undefined: no PARITY state, CSR bit [3] reads 0 and writes to it are ignored, frame is 10 bits.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - CSR bit-index localparams (CSR_BUSY=0, CSR_FULL=1, CSR_OVR=2, CSR_ODD=3);
  - default address constants.
- One natural sub-module, uart_baud_gen.
  - Function: counter with clear input and a one-cycle tick output at count CLKS_PER_BIT-1.
  - Reuse: the future receiver instantiates it too.

Test Plan (CLKS_PER_BIT=4):
- Single byte: write 8'hA5 to DATA_ADDR.
  - tx falls 2 cycles after the write edge.
  - Bits sampled mid-bit read 0,1,0,1,0,0,1,0,1, then stop=1.
  - busy=1 for 40 cycles; io_uart_io_reg=32'h000000A5.
- Back-to-back: write 8'h41, then 8'h42 while 8'h41 is in START.
  - Second frame starts immediately after the first stop bit (zero gap).
  - hold_full reads 1 then 0; overrun stays 0.
- Overrun: write 8'h01, 8'h02, 8'h03 on consecutive cycles.
  - Bytes 01 and 02 are transmitted; 03 is dropped.
  - csr[2]=1; CSR write 32'h4 clears it to 0.
- Ignored address: write 32'hFF to 8'h10.
  - tx stays 1; both register views unchanged.
- Reset mid-frame: drop rst during DATA bit 3.
  - tx=1 immediately, with no clock edge needed.
  - CSR=0; after release, a new write 8'h55 transmits correctly.
- With UART_TX_PARITY_EN, write 8'h07:
  - Parity bit = 1 (even); set CSR[3], resend, parity bit = 0.
  - Frame is 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit port and its helpers.
// UART_TX_PARITY_EN enables the optional PARITY state in the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int unsigned CSR_BUSY = 0;
   localparam int unsigned CSR_FULL = 1;
   localparam int unsigned CSR_OVR  = 2;
   localparam int unsigned CSR_ODD  = 3;

   localparam logic [7:0] DEF_DATA_ADDR = 8'h00;
   localparam logic [7:0] DEF_CSR_ADDR  = 8'h04;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and pulses o_tick on the last count.
// Shared by the transmitter and the future receiver.
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   output logic o_tick
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clear || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter with a one-byte holding register on the IO bus.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd via CSR bit 3).
module uart_tx_port
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter logic [7:0]  DATA_ADDR    = DEF_DATA_ADDR,
   parameter logic [7:0]  CSR_ADDR     = DEF_CSR_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_we,
   input  logic [7:0]  io_addr,
   input  logic [31:0] io_data,
   output logic        tx,
   output logic [31:0] io_uart_io_reg,
   output logic [31:0] io_uart_csr_reg
);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_port: CLKS_PER_BIT must be >= 2");
   end

   tx_state_t   r_state;
   logic [7:0]  r_shift;
   logic [7:0]  r_hold;
   logic [2:0]  r_idx;
   logic        r_full;
   logic        r_ovr;
   logic        w_tick;
   logic        w_baud_clr;
   logic        w_data_wr;
   logic        w_csr_wr;
   logic        w_drain;
   logic        w_accept;
   logic        w_unused;
`ifdef UART_TX_PARITY_EN
   logic        r_par;
   logic        r_odd;
`endif

   assign w_baud_clr = (r_state == IDLE);
   assign w_data_wr  = io_we && (io_addr == DATA_ADDR);
   assign w_csr_wr   = io_we && (io_addr == CSR_ADDR);
   // The FSM empties the holding register this cycle: a new byte may land in the same edge.
   assign w_drain    = r_full && ((r_state == IDLE) || ((r_state == STOP) && w_tick));
   assign w_accept   = w_data_wr && (!r_full || w_drain);
   assign w_unused   = ^io_data[31:8];

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .i_clk  (clk),
      .i_rst_n(rst),
      .i_clear(w_baud_clr),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold         <= '0;
         r_full         <= 1'b0;
         r_ovr          <= 1'b0;
         io_uart_io_reg <= '0;
`ifdef UART_TX_PARITY_EN
         r_odd          <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_hold         <= io_data[7:0];
            r_full         <= 1'b1;
            io_uart_io_reg <= {24'h0, io_data[7:0]};
         end else if (w_drain) begin
            r_full <= 1'b0;
         end
         if (w_data_wr && !w_accept) begin
            r_ovr <= 1'b1;
         end else if (w_csr_wr && io_data[CSR_OVR]) begin
            r_ovr <= 1'b0;
         end
`ifdef UART_TX_PARITY_EN
         if (w_csr_wr) begin
            r_odd <= io_data[CSR_ODD];
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (r_full) begin
                  r_shift <= r_hold;
`ifdef UART_TX_PARITY_EN
                  r_par   <= ^r_hold;
`endif
                  r_state <= START;
               end
            end
            START: begin
               if (w_tick) begin
                  r_idx   <= '0;
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_tick) begin
                  r_shift <= {1'b0, r_shift[7:1]};
                  r_idx   <= r_idx + 3'd1;
                  if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= PARITY;
`else
                     r_state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (w_tick) begin
                  r_state <= STOP;
               end
            end
`endif
            STOP: begin
               if (w_tick) begin
                  if (r_full) begin
                     r_shift <= r_hold;
`ifdef UART_TX_PARITY_EN
                     r_par   <= ^r_hold;
`endif
                     r_state <= START;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase

         // tx is registered from the current state, so the line trails the FSM by one cycle.
         case (r_state)
            START:   tx <= 1'b0;
            DATA:    tx <= r_shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx <= r_par ^ r_odd;
`endif
            default: tx <= 1'b1;
         endcase
      end
   end

   always_comb begin
      io_uart_csr_reg           = '0;
      io_uart_csr_reg[CSR_BUSY] = (r_state != IDLE);
      io_uart_csr_reg[CSR_FULL] = r_full;
      io_uart_csr_reg[CSR_OVR]  = r_ovr;
`ifdef UART_TX_PARITY_EN
      io_uart_csr_reg[CSR_ODD]  = r_odd;
`endif
   end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: directed scenarios plus random bus traffic against a frame-schedule model.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx_port;

   localparam int unsigned CPB    = 4;
   localparam logic [7:0]  DATA_A = 8'h00;
   localparam logic [7:0]  CSR_A  = 8'h04;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NB = 11;
`else
   localparam int unsigned NB = 10;
`endif
   localparam int unsigned FL = NB * CPB;

   logic        clk = 1'b0;
   logic        rst;
   logic        io_we;
   logic [7:0]  io_addr;
   logic [31:0] io_data;
   logic        tx;
   logic [31:0] io_uart_io_reg;
   logic [31:0] io_uart_csr_reg;

   uart_tx_port #(
      .CLKS_PER_BIT(CPB),
      .DATA_ADDR   (DATA_A),
      .CSR_ADDR    (CSR_A)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .io_we          (io_we),
      .io_addr        (io_addr),
      .io_data        (io_data),
      .tx             (tx),
      .io_uart_io_reg (io_uart_io_reg),
      .io_uart_csr_reg(io_uart_csr_reg)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model: byte acceptance and frame schedule ----------------
   typedef struct {
      logic [7:0]  b;
      logic        par;
      logic        stop;
      int unsigned fall;
   } frame_t;

   frame_t      obs_q[$];
   logic [7:0]  exp_b[$];
   logic        exp_par[$];
   int unsigned exp_fall[$];

   bit          hold_v      = 1'b0;
   int unsigned hold_w      = 0;
   int unsigned busy_until  = 0;
   logic        m_ovr       = 1'b0;
   logic        m_odd       = 1'b0;
   logic [7:0]  m_io        = 8'h00;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // A frame leaving IDLE at edge d: line falls one edge later, next reload possible at d+FL.
   function automatic void m_start(input int unsigned d);
      exp_fall.push_back(d + 1);
      busy_until = d + FL;
      hold_v     = 1'b0;
   endfunction

   function automatic void m_advance(input int unsigned w);
      int unsigned d;
      if (hold_v) begin
         d = max_u(hold_w + 1, busy_until);
         if (d <= w) m_start(d);
      end
   endfunction

   function automatic void m_data_write(input int unsigned w, input logic [7:0] b);
      m_advance(w);
      if (!hold_v) begin
         hold_v = 1'b1;
         hold_w = w;
         exp_b.push_back(b);
         exp_par.push_back((^b) ^ m_odd);
         m_io = b;
      end else begin
         m_ovr = 1'b1;
      end
   endfunction

   function automatic void m_csr_write(input logic [31:0] d);
      if (d[2]) m_ovr = 1'b0;
`ifdef UART_TX_PARITY_EN
      m_odd = d[3];
`endif
   endfunction

   function automatic void m_reset();
      hold_v = 1'b0;
      busy_until = 0;
      m_ovr = 1'b0;
      m_odd = 1'b0;
      m_io = 8'h00;
      obs_q.delete();
      exp_b.delete();
      exp_par.delete();
      exp_fall.delete();
   endfunction

   // ---------------- line monitor: decodes frames sampled mid-bit ----------------
   bit          mon_act = 1'b0;
   int unsigned mon_f   = 0;
   int unsigned mon_off = 0;
   logic [10:0] mon_bits = '1;

   always @(negedge clk) begin
      frame_t fr;
      if (!rst) begin
         mon_act = 1'b0;
      end else if (!mon_act) begin
         if (tx === 1'b0) begin
            mon_act = 1'b1;
            mon_f   = cyc;
         end
      end else begin
         mon_off = cyc - mon_f;
         if (mon_off % CPB == CPB / 2) mon_bits[mon_off / CPB] = tx;
         if (mon_off == FL - 1) begin
            fr.b    = mon_bits[8:1];
            fr.par  = mon_bits[9];
            fr.stop = mon_bits[NB-1];
            fr.fall = mon_f;
            obs_q.push_back(fr);
            mon_act = 1'b0;
         end
      end
   end

   // ---------------- bus helpers ----------------
   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      int unsigned w;
      @(negedge clk);
      w       = cyc + 1;
      io_we   = 1'b1;
      io_addr = a;
      io_data = d;
      if (a == DATA_A)     m_data_write(w, d[7:0]);
      else if (a == CSR_A) m_csr_write(d);
   endtask

   task automatic bus_idle(input int unsigned n);
      repeat (n) begin
         @(negedge clk);
         io_we = 1'b0;
      end
   endtask

   task automatic wait_done();
      if (hold_v) m_start(max_u(hold_w + 1, busy_until));
      while (cyc < busy_until + 6) @(negedge clk);
   endtask

   task automatic compare_frames(input string tag);
      check_eq({tag, " nframes"}, obs_q.size(), exp_b.size());
      for (int i = 0; i < obs_q.size() && i < exp_b.size(); i++) begin
         check_eq($sformatf("%s byte%0d", tag, i), obs_q[i].b, exp_b[i]);
         check_eq($sformatf("%s fall%0d", tag, i), obs_q[i].fall, exp_fall[i]);
         check_eq($sformatf("%s stop%0d", tag, i), obs_q[i].stop, 1'b1);
`ifdef UART_TX_PARITY_EN
         check_eq($sformatf("%s par%0d", tag, i), obs_q[i].par, exp_par[i]);
`endif
      end
      obs_q.delete();
      exp_b.delete();
      exp_par.delete();
      exp_fall.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int unsigned n;
      logic [7:0]  b;
      logic [31:0] d;
      int unsigned r;

      rst = 1'b0; io_we = 1'b0; io_addr = '0; io_data = '0;
      repeat (3) @(negedge clk);
      check_eq("rst tx", tx, 1'b1);
      check_eq("rst csr", io_uart_csr_reg, 32'h0);
      check_eq("rst io", io_uart_io_reg, 32'h0);
      rst = 1'b1;
      bus_idle(2);

      // single byte
      bus_write(DATA_A, 32'h0000_00A5);
      bus_idle(1);
      check_eq("single csr_full", io_uart_csr_reg, 32'h2);
      @(negedge clk);
      check_eq("single csr_busy", io_uart_csr_reg, 32'h1);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         if (!io_uart_csr_reg[0]) break;
         n++;
         @(negedge clk);
      end
      check_eq("single busy_len", n, FL);
      check_eq("single io", io_uart_io_reg, 32'h0000_00A5);
      wait_done();
      compare_frames("single");

      // back-to-back
      bus_write(DATA_A, 32'h41);
      bus_idle(2);
      bus_write(DATA_A, 32'h42);
      bus_idle(1);
      check_eq("b2b full", io_uart_csr_reg[1], 1'b1);
      wait_done();
      if (obs_q.size() >= 2) check_eq("b2b gap", obs_q[1].fall - obs_q[0].fall, FL);
      check_eq("b2b full_after", io_uart_csr_reg[1], 1'b0);
      check_eq("b2b ovr", io_uart_csr_reg[2], m_ovr);
      compare_frames("b2b");

      // overrun
      bus_write(DATA_A, 32'h01);
      bus_write(DATA_A, 32'h02);
      bus_write(DATA_A, 32'h03);
      bus_idle(1);
      check_eq("ovr set", io_uart_csr_reg[2], m_ovr);
      check_eq("ovr io", io_uart_io_reg, {24'h0, m_io});
      bus_write(CSR_A, 32'h4);
      bus_idle(1);
      check_eq("ovr clear", io_uart_csr_reg[2], m_ovr);
      wait_done();
      compare_frames("ovr");

      // ignored address
      bus_write(8'h10, 32'hFF);
      n = 0;
      for (int k = 0; k < 12; k++) begin
         bus_idle(1);
         if (tx !== 1'b1) n++;
      end
      check_eq("ign tx_low", n, 0);
      check_eq("ign io", io_uart_io_reg, {24'h0, m_io});
      check_eq("ign csr", io_uart_csr_reg, {28'h0, m_odd, m_ovr, 2'b00});

      // reset in the middle of data bit 3
      b = 8'($urandom) & 8'hF7;
      bus_write(DATA_A, {24'h0, b});
      bus_idle(1);
      repeat (19) @(negedge clk);
      check_eq("mid pre_tx", tx, 1'b0);
      rst = 1'b0;
      #1;
      check_eq("mid tx", tx, 1'b1);
      check_eq("mid csr", io_uart_csr_reg, 32'h0);
      check_eq("mid io", io_uart_io_reg, 32'h0);
      repeat (2) @(negedge clk);
      m_reset();
      rst = 1'b1;
      bus_idle(2);
      bus_write(DATA_A, 32'h55);
      bus_idle(1);
      wait_done();
      compare_frames("after_rst");

`ifdef UART_TX_PARITY_EN
      bus_write(DATA_A, 32'h07);
      bus_idle(1);
      wait_done();
      compare_frames("par_even");
      bus_write(CSR_A, 32'h8);
      bus_idle(1);
      check_eq("par odd_bit", io_uart_csr_reg[3], m_odd);
      bus_write(DATA_A, 32'h07);
      bus_idle(1);
      wait_done();
      compare_frames("par_odd");
`endif

      // random traffic
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6) begin
            bus_write(DATA_A, $urandom);
         end else if (r < 8) begin
            d = $urandom & 32'hFFFF_FFF3;
            d[3] = m_odd;
            bus_write(CSR_A, d);
         end else begin
            bus_write(8'($urandom_range(8, 255)), $urandom);
         end
         if ($urandom_range(0, 3) == 0) bus_idle($urandom_range(10, 60));
         else bus_idle($urandom_range(0, 2));
      end
      bus_idle(1);
      wait_done();
      check_eq("rand io", io_uart_io_reg, {24'h0, m_io});
      check_eq("rand csr", io_uart_csr_reg, {28'h0, m_odd, m_ovr, 2'b00});
      compare_frames("rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
